dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be W=8 (data width), A=8 (address width) and MAX_BURST=4 (maximum consecutive locked grants, range 1..15).
REQ-002 Port list, clock and reset first:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high.
- a_req, b_req  in  1  access request per port.
- a_lock, b_lock  in  1  hold ownership for a burst.
- a_we, b_we  in  1  write enable per port.
- a_addr, b_addr  in  A  address per port.
- a_wdata, b_wdata  in  W  write data per port.
- a_gnt, b_gnt  out  1  access accepted this cycle.
- a_rvalid, b_rvalid  out  1  read data valid.
- a_rdata, b_rdata  out  W  read data.
- mem_we  out  1  memory write enable.
- mem_addr  out  A  memory address.
- mem_din  out  W  memory write data.
- mem_dout  in  W  combinational memory read data.
REQ-003 Reset SHALL be synchronous and active-high on input Reset, with clock Clk; all state SHALL update on posedge Clk only.

Function
REQ-004 States SHALL be IDLE, OWN_A and OWN_B.
REQ-005 Grants SHALL be combinational, at most one per cycle; a_gnt and b_gnt SHALL never both be 1.
REQ-006 In IDLE, a lone requester SHALL be granted; with both requesting, the port not granted most recently (last-winner register) SHALL win.
REQ-007 In OWN_x only port x SHALL be grantable; the other port's req SHALL wait with gnt=0.
REQ-008 mem_addr and mem_din SHALL mux from the granted port; with no grant they SHALL follow port A, and mem_we SHALL be 0.
REQ-009 mem_we SHALL equal granted port's we; the write completes at that posedge.
REQ-010 A granted read SHALL register mem_dout into x_rdata at that posedge and pulse x_rvalid for exactly the next cycle (latency 1); x_rdata SHALL hold its value until the next read by x.
REQ-011 A granted write SHALL NOT assert rvalid.
REQ-012 Granting x with x_lock=1 SHALL move IDLE to OWN_x and load the burst count with 1; each further grant in OWN_x SHALL increment it.
REQ-013 OWN_x SHALL return to IDLE after a grant where x_lock=0, or where the count reaches MAX_BURST, or in any cycle where x_req=0.
REQ-014 On every grant the last-winner register SHALL update to the granted port, so the other port wins the next contended IDLE arbitration.
REQ-015 With MAX_BURST=1, a locked request SHALL behave as unlocked.

Reset
REQ-016 On Reset: state IDLE; burst count 0; last-winner B, so A wins first contention; a_rvalid, b_rvalid 0; a_rdata, b_rdata 0.
REQ-017 While Reset=1, a_gnt, b_gnt and mem_we SHALL be 0; Reset mid-burst SHALL abort the burst and drop any pending rvalid.

Configuration
REQ-018 With macro DMEM_ARBITER_STATS_EN defined, the block SHALL add the following outputs:
- a_cnt, b_cnt  out  16  saturating grant counts per port.
- conflict_cnt  out  16  saturating count of cycles where a request waited without grant.
All three SHALL be cleared by Reset.
REQ-019 Without DMEM_ARBITER_STATS_EN, those ports and their counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-020 After reset, a_req=b_req=1, both reads at addresses 0x10 and 0x20 -> cycle 0 a_gnt=1 with mem_addr=0x10; cycle 1 b_gnt=1 with mem_addr=0x20 and a_rvalid=1 carrying mem_dout of 0x10.
REQ-021 A writes 0x5A to 0x03, then reads 0x03 next cycle -> mem_we=1 only in the write cycle; a_rvalid one cycle after the read with a_rdata=0x5A.
REQ-022 A holds req+lock for 6 cycles while b_req=1 -> a_gnt for cycles 0-3, b_gnt at cycle 4, a_gnt at cycle 5.
REQ-023 B locked burst; b_lock drops after 2nd grant while a_req=1 -> A granted the following cycle.
REQ-024 Reset asserted during OWN_A with a read granted the previous cycle -> a_rvalid=0, gnts=0, state IDLE; after release, contention is won by A.
REQ-025 With DMEM_ARBITER_STATS_EN defined, 10 contended cycles -> a_cnt+b_cnt=10 and conflict_cnt=10.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two data-memory clients, the dmem_arbiter and a single-port memory.
// Optional statistics outputs are present only when DMEM_ARBITER_STATS_EN is defined.
interface dmem_arbiter_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic         a_req,    b_req;
    logic         a_lock,   b_lock;
    logic         a_we,     b_we;
    logic [A-1:0] a_addr,   b_addr;
    logic [W-1:0] a_wdata,  b_wdata;
    logic         a_gnt,    b_gnt;
    logic         a_rvalid, b_rvalid;
    logic [W-1:0] a_rdata,  b_rdata;
    logic         mem_we;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_din;
    logic [W-1:0] mem_dout;
`ifdef DMEM_ARBITER_STATS_EN
    logic [15:0]  a_cnt, b_cnt, conflict_cnt;

    modport slave (
        input  a_req, b_req, a_lock, b_lock, a_we, b_we,
               a_addr, b_addr, a_wdata, b_wdata, mem_dout,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
               mem_we, mem_addr, mem_din, a_cnt, b_cnt, conflict_cnt
    );
    modport master (
        output a_req, b_req, a_lock, b_lock, a_we, b_we,
               a_addr, b_addr, a_wdata, b_wdata, mem_dout,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
               mem_we, mem_addr, mem_din, a_cnt, b_cnt, conflict_cnt
    );
`else
    modport slave (
        input  a_req, b_req, a_lock, b_lock, a_we, b_we,
               a_addr, b_addr, a_wdata, b_wdata, mem_dout,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
               mem_we, mem_addr, mem_din
    );
    modport master (
        output a_req, b_req, a_lock, b_lock, a_we, b_we,
               a_addr, b_addr, a_wdata, b_wdata, mem_dout,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
               mem_we, mem_addr, mem_din
    );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory: fair alternation on contention,
// locked bursts of up to MAX_BURST grants, 1-cycle read return. Stats: DMEM_ARBITER_STATS_EN.
module dmem_arbiter #(
    parameter int W         = 8,
    parameter int A         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t       state_q, state_d;
    logic [3:0]   burst_q, burst_d, burst_inc;
    logic         last_b_q, last_b_d;
    logic         a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic         a_gnt, b_gnt;
    logic [A-1:0] mem_addr;

    // Grants are combinational; Reset forces both low.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!Reset) begin
            case (state_q)
                IDLE: begin
                    if (bus.a_req && bus.b_req) begin
                        a_gnt = last_b_q;
                        b_gnt = !last_b_q;
                    end else begin
                        a_gnt = bus.a_req;
                        b_gnt = bus.b_req;
                    end
                end
                OWN_A:   a_gnt = bus.a_req;
                OWN_B:   b_gnt = bus.b_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        burst_inc = burst_q + 4'd1;
        case (state_q)
            IDLE: begin
                // A burst of one is just an unlocked access, so never enter OWN_x then.
                if (a_gnt && bus.a_lock && MAX_B > 4'd1) begin
                    state_d = OWN_A;
                    burst_d = 4'd1;
                end else if (b_gnt && bus.b_lock && MAX_B > 4'd1) begin
                    state_d = OWN_B;
                    burst_d = 4'd1;
                end
            end
            OWN_A: begin
                if (!a_gnt || !bus.a_lock || burst_inc >= MAX_B) begin
                    state_d = IDLE;
                    burst_d = 4'd0;
                end else begin
                    burst_d = burst_inc;
                end
            end
            OWN_B: begin
                if (!b_gnt || !bus.b_lock || burst_inc >= MAX_B) begin
                    state_d = IDLE;
                    burst_d = 4'd0;
                end else begin
                    burst_d = burst_inc;
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        last_b_d   = b_gnt ? 1'b1 : (a_gnt ? 1'b0 : last_b_q);
        a_rvalid_d = a_gnt && !bus.a_we;
        b_rvalid_d = b_gnt && !bus.b_we;
        a_rdata_d  = a_rvalid_d ? bus.mem_dout : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? bus.mem_dout : b_rdata_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            burst_q    <= 4'd0;
            last_b_q   <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            last_b_q   <= last_b_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign mem_addr     = b_gnt ? bus.b_addr : bus.a_addr;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = b_gnt ? bus.b_wdata : bus.a_wdata;
    assign bus.mem_we   = (a_gnt && bus.a_we) || (b_gnt && bus.b_we);
    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    // Masking with Reset drops a return that was already in flight when Reset rose.
    assign bus.a_rvalid = a_rvalid_q && !Reset;
    assign bus.b_rvalid = b_rvalid_q && !Reset;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;

`ifdef DMEM_ARBITER_STATS_EN
    logic [15:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, conflict_cnt_q, conflict_cnt_d;
    logic        waiting;

    always_comb begin
        waiting        = (bus.a_req && !a_gnt) || (bus.b_req && !b_gnt);
        a_cnt_d        = (a_gnt && a_cnt_q != 16'hFFFF) ? a_cnt_q + 16'd1 : a_cnt_q;
        b_cnt_d        = (b_gnt && b_cnt_q != 16'hFFFF) ? b_cnt_q + 16'd1 : b_cnt_q;
        conflict_cnt_d = (waiting && conflict_cnt_q != 16'hFFFF) ? conflict_cnt_q + 16'd1
                                                                  : conflict_cnt_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_cnt_q        <= 16'd0;
            b_cnt_q        <= 16'd0;
            conflict_cnt_q <= 16'd0;
        end else begin
            a_cnt_q        <= a_cnt_d;
            b_cnt_q        <= b_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.a_cnt        = a_cnt_q;
    assign bus.b_cnt        = b_cnt_q;
    assign bus.conflict_cnt = conflict_cnt_q;
`endif
endmodule
